hamming_rx_decoder: RTL and testbench
=====================================

// Module: hamming_rx_decoder
// PURPOSE
// - Sits directly downstream of the UART receiver; consumes its 7-bit Hamming(7,4) codewords (data_out/valid_out).
// - Corrects single-bit errors and extracts the 4-bit nibble.
// - Pairs nibbles into bytes and buffers them in a small FIFO with a valid/ready output handshake.
// - Keeps saturating counts of corrected codewords and dropped bytes.
// PARAMETERS
// - LOW_FIRST   1  1: first nibble of a pair is byte[3:0]; 0: first nibble is byte[7:4]
// - FIFO_DEPTH  4  output FIFO entries, power of 2, >= 2
// - CNT_W       8  width of the saturating statistics counters
// PORTS
// - clk         in   1      clock
// - rst_n       in   1      async active-low reset
// - ena         in   1      enable; when low, all state holds and cw_valid is ignored
// - cw_in       in   7      codeword, cw_in[k] = Hamming position k+1 (p1 p2 d1 p3 d2 d3 d4)
// - cw_valid    in   1      one-cycle strobe, cw_in valid
// - pair_clr    in   1      discard any pending first nibble (resync)
// - byte_out    out  8      FIFO head byte
// - byte_valid  out  1      FIFO non-empty
// - byte_ready  in   1      consumer accepts head when byte_valid & byte_ready
// - corr_cnt    out  CNT_W  codewords with nonzero syndrome, saturating
// - drop_cnt    out  CNT_W  bytes dropped on FIFO full, saturating
// - overflow    out  1      sticky, set on the first drop
// BEHAVIOUR
// - Reset values: byte_out=0, byte_valid=0, corr_cnt=0, drop_cnt=0, overflow=0; FIFO empty; pairing state = WAIT_FIRST.
// - Syndrome: s1=cw0^cw2^cw4^cw6; s2=cw1^cw2^cw5^cw6; s3=cw3^cw4^cw5^cw6.
//   - syn={s3,s2,s1}; syn!=0 flips cw[syn-1].
//   - Nibble = {cw6,cw5,cw4,cw2} taken after correction.
//   - Double errors are miscorrected silently. This is a property of (7,4) and is not flagged.
// - Pipeline:
//   - S1 registers the codeword and syndrome (cycle N+1 for a strobe at N).
//   - S2 registers the corrected nibble and the corr flag (N+2).
//   - A completed byte is pushed at the N+2 edge; byte_valid rises at N+3 if the FIFO was empty.
// - ena=0: S1/S2 valid bits, pairing state, FIFO pointers and counters all freeze. byte_valid keeps its value, but no pop occurs.
// - Pairing FSM:
//   - WAIT_FIRST: on S2 valid, store nibble -> WAIT_SECOND.
//   - WAIT_SECOND: on S2 valid, form the byte per LOW_FIRST and push -> WAIT_FIRST.
//   - pair_clr forces WAIT_FIRST and drops the held nibble.
//   - If pair_clr coincides with an S2 valid, pair_clr wins and that nibble becomes the new first nibble.
// - corr_cnt increments once per S2 nibble with syn!=0; it saturates at all-ones and never wraps.
// - FIFO:
//   - Push and pop in the same cycle are both honoured; occupancy is unchanged, including when full.
//   - Push when full without a pop: the byte is discarded, drop_cnt++ (saturating), overflow<=1.
//   - Pop when empty is impossible, because byte_valid=0.
//   - byte_out is stable while byte_valid & !byte_ready.
// - Async reset mid-frame clears pipeline, pairing and FIFO immediately. No partial byte survives.
// STRUCTURE
// - Shared package hamming_pkg:
//   - Pairing state localparams WAIT_FIRST=1'b0 and WAIT_SECOND=1'b1.
//   - Function ham74_syndrome(cw) -> [2:0].
//   - Function ham74_correct(cw) -> [6:0].
//   - Function ham74_encode(nib) -> [6:0]; the bench uses it.
// - One sub-module, hamming_byte_fifo (DEPTH, width 8, push/pop/full/empty, same clk/rst_n).
// - Syndrome, correction and pairing logic stay in the top module.
// TESTING
// 1. Clean pair, LOW_FIRST=1, byte_ready=1:
//    - Stimulus: cw 7'h2D (nibble 5) at N, then 7'h52 (nibble A) at N+3.
//    - Response: byte_out=8'hA5 with byte_valid high at N+6 for one cycle; corr_cnt=0.
// 2. Single-bit error:
//    - Stimulus: send 7'h42 (7'h52 with bit 4 flipped) as the second codeword after 7'h2D.
//    - Response: byte 8'hA5; corr_cnt=1.
//    - Repeat the flip at all 7 bit positions: always corrected, corr_cnt=7.
// 3. Backpressure and overflow, FIFO_DEPTH=4, byte_ready=0:
//    - Stimulus: send 5 byte pairs (0x11..0x55).
//    - Response: FIFO holds 0x11..0x44; drop_cnt=1; overflow=1.
//    - Then raise byte_ready: 0x11,0x22,0x33,0x44 pop in order, then byte_valid=0.
// 4. Resync:
//    - Stimulus: send 7'h2D, pulse pair_clr, then 7'h52 and 7'h2D.
//    - Response: single byte 8'h5A; 7'h2D is not paired.
// 5. ena gating:
//    - Stimulus: drop ena between the two codewords of a pair while cw_valid pulses with 7'h00.
//    - Response: the garbage is ignored and the byte is still 8'hA5.
// 6. Reset mid-pair and saturation:
//    - Stimulus: assert rst_n low after the first nibble.
//    - Response: all outputs return to 0 and the next pair is formed cleanly.
//    - Separately, with CNT_W=2, send 5 corrupted codewords -> corr_cnt holds at 3.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) helpers and pairing-state encodings for the UART receive path.
// Codeword bit k holds Hamming position k+1: {d4,d3,d2,p3,d1,p2,p1}.
package hamming_pkg;

   localparam logic WAIT_FIRST  = 1'b0;
   localparam logic WAIT_SECOND = 1'b1;

   // syn = {s3,s2,s1}; a nonzero value is the 1-based position of the suspect bit
   function automatic logic [2:0] ham74_syndrome(input logic [6:0] cw);
      logic s1, s2, s3;
      s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
      s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
      s3 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
      return {s3, s2, s1};
   endfunction

   function automatic logic [6:0] ham74_correct(input logic [6:0] cw);
      logic [2:0] syn;
      logic [6:0] fixed;
      syn   = ham74_syndrome(cw);
      fixed = cw;
      if (syn != 3'd0) begin
         fixed = cw ^ (7'(1) << (syn - 3'd1));
      end
      return fixed;
   endfunction

   function automatic logic [6:0] ham74_encode(input logic [3:0] nib);
      logic p1, p2, p3;
      p1 = nib[0] ^ nib[1] ^ nib[3];
      p2 = nib[0] ^ nib[2] ^ nib[3];
      p3 = nib[1] ^ nib[2] ^ nib[3];
      return {nib[3], nib[2], nib[1], p3, nib[0], p2, p1};
   endfunction

endpackage

// File: rtl/hamming_byte_fifo.sv
// Small power-of-two FIFO with a registered head word; simultaneous push and pop
// are both honoured, including when full.
module hamming_byte_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr, rd_nxt_c;
   logic [CW-1:0]    cnt, cnt_nxt_c;
   logic             pop_ok_c, wr_ok_c;
   logic [WIDTH-1:0] head_c;

   // Next occupancy and next head; a write landing on the new head slot bypasses memory
   always_comb begin
      pop_ok_c  = pop && !empty;
      wr_ok_c   = push && (!full || pop_ok_c);
      cnt_nxt_c = cnt;
      if (wr_ok_c && !pop_ok_c) begin
         cnt_nxt_c = cnt + CW'(1);
      end else if (pop_ok_c && !wr_ok_c) begin
         cnt_nxt_c = cnt - CW'(1);
      end
      rd_nxt_c = pop_ok_c ? rd_ptr + AW'(1) : rd_ptr;
      head_c   = (wr_ok_c && (wr_ptr == rd_nxt_c)) ? wdata : mem[rd_nxt_c];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         rdata  <= '0;
      end else begin
         rd_ptr <= rd_nxt_c;
         if (wr_ok_c) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         cnt   <= cnt_nxt_c;
         full  <= (cnt_nxt_c == CW'(DEPTH));
         empty <= (cnt_nxt_c == '0);
         if (cnt_nxt_c != '0) begin
            rdata <= head_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok_c) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/hamming_rx_decoder.sv
// Corrects Hamming(7,4) codewords from the UART receiver, pairs nibbles into bytes
// and buffers them behind a valid/ready handshake with saturating statistics.
module hamming_rx_decoder #(
   parameter bit          LOW_FIRST  = 1'b1,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [6:0]       cw_in,
   input  logic             cw_valid,
   input  logic             pair_clr,
   output logic [7:0]       byte_out,
   output logic             byte_valid,
   input  logic             byte_ready,
   output logic [CNT_W-1:0] corr_cnt,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             overflow
);

   import hamming_pkg::*;

   logic       s1_valid;
   logic [6:0] s1_cw;
   logic [2:0] s1_syn;
   logic [6:0] s1_fix_c;
   logic       s2_valid;
   logic [3:0] s2_nib;
   logic       s2_corr;

   logic       pair_state;
   logic [3:0] held_nib;

   logic       push_c, pop_c, drop_c;
   logic [7:0] pair_byte_c;
   logic       fifo_full, fifo_empty;

   assign s1_fix_c = ham74_correct(s1_cw);

   // Two-stage decode pipeline; ena low freezes both stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_cw    <= '0;
         s1_syn   <= '0;
         s2_valid <= 1'b0;
         s2_nib   <= '0;
         s2_corr  <= 1'b0;
      end else if (ena) begin
         s1_valid <= cw_valid;
         if (cw_valid) begin
            s1_cw  <= cw_in;
            s1_syn <= ham74_syndrome(cw_in);
         end
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_nib  <= {s1_fix_c[6], s1_fix_c[5], s1_fix_c[4], s1_fix_c[2]};
            s2_corr <= (s1_syn != 3'd0);
         end
      end
   end

   always_comb begin
      push_c      = ena && s2_valid && !pair_clr && (pair_state == WAIT_SECOND);
      pair_byte_c = LOW_FIRST ? {s2_nib, held_nib} : {held_nib, s2_nib};
      pop_c       = ena && !fifo_empty && byte_ready;
      drop_c      = push_c && fifo_full && !pop_c;
   end

   // Pairing: pair_clr outranks a completing nibble, which then starts a new pair
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_state <= WAIT_FIRST;
         held_nib   <= '0;
      end else if (ena) begin
         if (pair_clr) begin
            pair_state <= s2_valid ? WAIT_SECOND : WAIT_FIRST;
            if (s2_valid) begin
               held_nib <= s2_nib;
            end
         end else if (s2_valid) begin
            if (pair_state == WAIT_FIRST) begin
               held_nib   <= s2_nib;
               pair_state <= WAIT_SECOND;
            end else begin
               pair_state <= WAIT_FIRST;
            end
         end
      end
   end

   // Saturating statistics and sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_cnt <= '0;
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else if (ena) begin
         if (s2_valid && s2_corr && (corr_cnt != '1)) begin
            corr_cnt <= corr_cnt + CNT_W'(1);
         end
         if (drop_c) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + CNT_W'(1);
            end
         end
      end
   end

   hamming_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_c),
      .pop   (pop_c),
      .wdata (pair_byte_c),
      .rdata (byte_out),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign byte_valid = ~fifo_empty;

endmodule

// File: tb/tb_hamming_rx_decoder.sv
// Bench for hamming_rx_decoder: directed scenarios plus a randomized stream checked
// against a nibble-pairing/byte-queue reference model.
module tb_hamming_rx_decoder;

   import hamming_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [6:0] cw_in;
   logic       cw_valid;
   logic       pair_clr;
   logic       byte_ready;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic [7:0] corr_cnt, drop_cnt;
   logic       overflow;
   logic [7:0] sat_byte_out;
   logic       sat_byte_valid;
   logic [1:0] sat_corr_cnt, sat_drop_cnt;
   logic       sat_overflow;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   bit         mon_en = 1'b0;
   int         lowrun = 0;

   always #5 clk = ~clk;

   hamming_rx_decoder #(.LOW_FIRST(1'b1), .FIFO_DEPTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .cw_in(cw_in), .cw_valid(cw_valid),
      .pair_clr(pair_clr), .byte_out(byte_out), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .corr_cnt(corr_cnt), .drop_cnt(drop_cnt),
      .overflow(overflow)
   );

   hamming_rx_decoder #(.LOW_FIRST(1'b1), .FIFO_DEPTH(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .ena(ena), .cw_in(cw_in), .cw_valid(cw_valid),
      .pair_clr(pair_clr), .byte_out(sat_byte_out), .byte_valid(sat_byte_valid),
      .byte_ready(byte_ready), .corr_cnt(sat_corr_cnt), .drop_cnt(sat_drop_cnt),
      .overflow(sat_overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [6:0] cw);
      cw_in    = cw;
      cw_valid = 1'b1;
      tick();
      cw_valid = 1'b0;
   endtask

   // Waits a bounded number of cycles for a handshake; returns just after the pop edge
   task automatic get_byte(output logic [7:0] b, output bit ok);
      ok = 1'b0;
      b  = '0;
      for (int i = 0; i < 16 && !ok; i++) begin
         @(negedge clk);
         if (byte_valid && byte_ready && ena) begin
            b  = byte_out;
            ok = 1'b1;
         end
      end
      tick();
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] exp);
      logic [7:0] b;
      bit         ok;
      get_byte(b, ok);
      check({tag, "_seen"}, 32'(ok), 32'd1);
      check(tag, 32'(b), 32'(exp));
   endtask

   task automatic rnd_cycle();
      if (lowrun >= 3 || $urandom_range(0, 3) != 0) begin
         byte_ready = 1'b1;
         lowrun     = 0;
      end else begin
         byte_ready = 1'b0;
         lowrun++;
      end
      tick();
   endtask

   // Stream scoreboard: every accepted byte must be the oldest expected one
   always @(negedge clk) begin
      if (mon_en && rst_n && ena && byte_valid && byte_ready) begin
         if (exp_q.size() == 0) check("rnd_extra_byte", 32'(byte_out), 32'hFFFF_FFFF);
         else check("rnd_byte", 32'(byte_out), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got running exp finished");
      $fatal(1);
   end

   initial begin
      logic [3:0] nib, pend_nib;
      logic [6:0] err;
      bit         pend_v;
      int         exp_corr;

      rst_n = 1'b0; ena = 1'b1; cw_in = '0; cw_valid = 1'b0; pair_clr = 1'b0; byte_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_byte_out", 32'(byte_out), 0);
      check("rst_byte_valid", 32'(byte_valid), 0);
      check("rst_corr", 32'(corr_cnt), 0);
      check("rst_drop", 32'(drop_cnt), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_sat_all", 32'({sat_byte_out, sat_byte_valid, sat_corr_cnt, sat_drop_cnt, sat_overflow}), 0);
      rst_n = 1'b1;
      tick();

      // 1: clean pair, exact latency
      byte_ready = 1'b1;
      send(7'h2D);
      tick(); tick();
      send(7'h52);
      tick();
      @(negedge clk); check("t1_early", 32'(byte_valid), 0);
      tick();
      @(negedge clk); check("t1_valid", 32'(byte_valid), 1);
      check("t1_byte", 32'(byte_out), 32'hA5);
      tick();
      @(negedge clk); check("t1_one_cycle", 32'(byte_valid), 0);
      check("t1_corr", 32'(corr_cnt), 0);
      tick();

      // 2: single-bit error at every position; CNT_W=2 instance saturates at 3
      for (int k = 0; k < 7; k++) begin
         send(7'h2D);
         send(7'h52 ^ (7'(1) << k));
         expect_byte("t2_byte", 8'hA5);
         @(negedge clk);
         check("t2_corr", 32'(corr_cnt), 32'(k + 1));
         check("t2_sat_corr", 32'(sat_corr_cnt), 32'(sat(k + 1, 3)));
         tick();
      end

      // 3: backpressure and overflow
      byte_ready = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         send(ham74_encode(4'(n)));
         send(ham74_encode(4'(n)));
      end
      repeat (4) tick();
      @(negedge clk);
      check("t3_valid", 32'(byte_valid), 1);
      check("t3_head", 32'(byte_out), 32'h11);
      check("t3_drop", 32'(drop_cnt), 1);
      check("t3_ovf", 32'(overflow), 1);
      tick();
      byte_ready = 1'b1;
      for (int n = 1; n <= 4; n++) expect_byte("t3_pop", 8'(n * 17));
      @(negedge clk); check("t3_empty", 32'(byte_valid), 0);
      tick();

      // 4: resync drops held nibble
      send(7'h2D);
      tick(); tick();
      pair_clr = 1'b1; tick(); pair_clr = 1'b0;
      send(7'h52);
      send(7'h2D);
      expect_byte("t4_byte", 8'h5A);
      repeat (5) tick();
      @(negedge clk); check("t4_no_extra", 32'(byte_valid), 0);
      tick();

      // 4b: pair_clr coinciding with a completing nibble restarts the pair with it
      send(7'h52);
      send(7'h2D);
      tick();
      pair_clr = 1'b1; tick(); pair_clr = 1'b0;
      send(7'h52);
      expect_byte("t4b_byte", 8'hA5);

      // 5: ena gating, including garbage strobes and a stray pair_clr
      send(7'h2D);
      ena = 1'b0;
      send(7'h00);
      pair_clr = 1'b1;
      send(7'h01);
      pair_clr = 1'b0;
      send(7'h00);
      ena = 1'b1;
      send(7'h52);
      expect_byte("t5_byte", 8'hA5);
      @(negedge clk); check("t5_corr", 32'(corr_cnt), 7);
      tick();
      byte_ready = 1'b0;
      send(ham74_encode(4'h6));
      send(ham74_encode(4'h9));
      repeat (4) tick();
      ena = 1'b0;
      byte_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("t5_hold_valid", 32'(byte_valid), 1);
      check("t5_hold_byte", 32'(byte_out), 32'h96);
      tick();
      ena = 1'b1;
      expect_byte("t5_after_ena", 8'h96);

      // 6: async reset mid-pair with a buffered byte
      byte_ready = 1'b0;
      send(ham74_encode(4'h3));
      send(ham74_encode(4'h3));
      send(ham74_encode(4'h5) ^ 7'h04);
      repeat (4) tick();
      @(negedge clk); check("t6_pre_valid", 32'(byte_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(byte_valid), 0);
      check("t6_rst_byte", 32'(byte_out), 0);
      check("t6_rst_cnts", 32'({corr_cnt, drop_cnt, overflow}), 0);
      check("t6_rst_sat", 32'({sat_byte_out, sat_byte_valid, sat_corr_cnt, sat_drop_cnt, sat_overflow}), 0);
      @(negedge clk); rst_n = 1'b1;
      tick();
      byte_ready = 1'b1;
      send(7'h52);
      send(7'h2D);
      expect_byte("t6_clean_pair", 8'h5A);

      // Randomized stream against the reference model
      pend_v = 1'b0; pend_nib = '0; exp_corr = 0;
      mon_en = 1'b1;
      for (int i = 0; i < 240; i++) begin
         if (i % 24 == 23) begin
            ena = 1'b1; cw_valid = 1'b0;
            repeat (3) rnd_cycle();
            pair_clr = 1'b1; rnd_cycle(); pair_clr = 1'b0;
            pend_v = 1'b0;
         end
         nib = 4'($urandom_range(0, 15));
         begin
            int pos;
            pos = $urandom_range(0, 13);
            err = (pos < 7) ? (7'(1) << pos) : 7'h00;
         end
         if (err != 7'h00) exp_corr++;
         if (pend_v) begin
            exp_q.push_back({nib, pend_nib});
            pend_v = 1'b0;
         end else begin
            pend_nib = nib;
            pend_v   = 1'b1;
         end
         ena = 1'b1; cw_in = ham74_encode(nib) ^ err; cw_valid = 1'b1;
         rnd_cycle();
         cw_valid = 1'b0;
         for (int g = 0; g < int'($urandom_range(2, 5)); g++) begin
            if ($urandom_range(0, 3) == 0) begin
               ena = 1'b0; cw_valid = 1'b1; cw_in = 7'($urandom);
            end else begin
               ena = 1'b1; cw_valid = 1'b0;
            end
            rnd_cycle();
         end
         ena = 1'b1; cw_valid = 1'b0;
      end
      byte_ready = 1'b1;
      repeat (20) tick();
      mon_en = 1'b0;
      check("rnd_left", 32'(exp_q.size()), 0);
      @(negedge clk);
      check("rnd_corr", 32'(corr_cnt), 32'(sat(exp_corr, 255)));
      check("rnd_sat_corr", 32'(sat_corr_cnt), 32'(sat(exp_corr, 3)));
      check("rnd_drop", 32'(drop_cnt), 0);
      check("rnd_ovf", 32'(overflow), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
